// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: decides stall/flush/enable for a 5-stage pipe
// from load-use, redirect, fetch and data-memory wait conditions.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  imem_ready,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  input  logic                  halt_req,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  typedef enum logic [1:0] {RUN, DMEM_WAIT, HALT} state_e;

  state_e           state_q, state_d;
  logic             load_use, freeze, redirect, active;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    halted      = 1'b0;
    freeze      = 1'b0;
    redirect    = 1'b0;
    active      = 1'b0;
    // x0 is hardwired, so a load targeting it never creates a dependency
    load_use = ex_mem_read && (ex_rd != '0) &&
               ((id_rs1_used && (id_rs1 == ex_rd)) ||
                (id_rs2_used && (id_rs2 == ex_rd)));

    case (state_q)
      RUN, DMEM_WAIT: begin
        active   = 1'b1;
        if_id_en = 1'b1;
        freeze   = (state_q == DMEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);
        if (freeze) begin
          if_id_stall = 1'b1;
          state_d     = DMEM_WAIT;
        end else begin
          ex_mem_en = 1'b1;
          state_d   = RUN;
          if (ex_branch_taken) begin
            redirect    = 1'b1;
            pc_en       = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            if_id_flush = 1'b1;
          end else begin
            pc_en = 1'b1;
          end
          // halt is only honoured from RUN, after this cycle's action retires
          if ((state_q == RUN) && halt_req) state_d = HALT;
        end
      end
      HALT:    halted  = 1'b1;
      default: state_d = RUN;
    endcase

    stall_d = stall_q;
    if (active && !pc_en && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    flush_d = flush_q;
    if (redirect && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);

    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      ex_mem_en   = 1'b0;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic, all
// compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int AW    = 5;
  localparam int CW    = 8;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_rs1_used = 1'b0, id_rs2_used = 1'b0, ex_mem_read = 1'b0;
  logic          ex_branch_taken = 1'b0, imem_ready = 1'b1, dmem_req = 1'b0;
  logic          dmem_ready = 1'b0, halt_req = 1'b0;
  logic          pc_en, if_id_en, if_id_stall, if_id_flush, id_ex_flush, ex_mem_en, halted;
  logic [CW-1:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  // reference model state: plain flags and integer counters
  bit m_wait = 0, m_halt = 0;
  int m_stall = 0, m_flush = 0;

  pipe_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .halt_req(halt_req), .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .halted(halted), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ctl_now();
    return {pc_en, if_id_en, if_id_stall, if_id_flush, id_ex_flush, ex_mem_en, halted};
  endfunction

  // expected {pc_en,if_id_en,if_id_stall,if_id_flush,id_ex_flush,ex_mem_en,halted}
  function automatic logic [6:0] model_ctl(output bit rule2, output bit nw, output bit nh);
    bit hz, frz;
    rule2 = 0; nw = 0; nh = m_halt;
    if (m_halt) return 7'b0000001;
    hz  = ex_mem_read && ex_rd != 0 &&
          ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    frz = m_wait ? !dmem_ready : (dmem_req && !dmem_ready);
    nw  = frz;
    nh  = !m_wait && !frz && halt_req;
    if (frz)                  return 7'b0110000;
    if (ex_branch_taken) begin rule2 = 1; return 7'b1101110; end
    if (hz)                   return 7'b0110110;
    if (!imem_ready)          return 7'b0101010;
    return 7'b1100010;
  endfunction

  task automatic cycle(input string tag);
    logic [6:0] e;
    bit r2, nw, nh;
    @(negedge clk);
    e = model_ctl(r2, nw, nh);
    chk({tag, "/ctl"}, 32'(ctl_now()), 32'(e));
    @(posedge clk); #1;
    if (!m_halt) begin
      if (!e[6] && m_stall < MAXC) m_stall++;
      if (r2 && m_flush < MAXC) m_flush++;
    end
    m_wait = nw;
    m_halt = nh;
    chk({tag, "/stall"}, 32'(stall_cycles), 32'(m_stall));
    chk({tag, "/flush"}, 32'(flush_count), 32'(m_flush));
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0; ex_rd = 0;
    ex_mem_read = 0; ex_branch_taken = 0; imem_ready = 1; dmem_req = 0;
    dmem_ready = 0; halt_req = 0;
  endtask

  task automatic randin();
    id_rs1 = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
    ex_rd  = AW'($urandom_range(0, 3));
    id_rs1_used = 1'($urandom_range(0, 1)); id_rs2_used = 1'($urandom_range(0, 1));
    ex_mem_read = ($urandom_range(0, 99) < 50);
    ex_branch_taken = ($urandom_range(0, 99) < 20);
    imem_ready = ($urandom_range(0, 99) < 80);
    dmem_req   = ($urandom_range(0, 99) < 30);
    dmem_ready = ($urandom_range(0, 99) < 50);
    halt_req   = ($urandom_range(0, 99) < 2);
  endtask

  // asynchronous reset pulse launched mid-cycle
  task automatic do_reset(input string tag);
    rst = 1; #1;
    chk({tag, "/rst_ctl"}, 32'(ctl_now()), 32'h0);
    chk({tag, "/rst_stall"}, 32'(stall_cycles), 32'h0);
    chk({tag, "/rst_flush"}, 32'(flush_count), 32'h0);
    m_wait = 0; m_halt = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    chk({tag, "/rst_hold"}, 32'(ctl_now()), 32'h0);
    @(posedge clk); #1;
    chk({tag, "/rst_edge"}, 32'({ctl_now(), stall_cycles}), 32'h0);
    rst = 0;
  endtask

  initial begin
    // reset held across edges with busy inputs
    randin();
    repeat (2) @(negedge clk);
    chk("reset_ctl", 32'(ctl_now()), 32'h0);
    chk("reset_cnt", 32'({stall_cycles, flush_count}), 32'h0);
    @(posedge clk); #1;
    rst = 0; idle();
    cycle("normal");

    // load x5 in EX, ID reads x5 through rs2
    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
    cycle("load_use");
    chk("load_use_cnt", 32'(stall_cycles), 32'd1);

    // branch wins over a simultaneous load-use hazard
    ex_branch_taken = 1;
    cycle("br_over_hz");
    chk("br_flush_cnt", 32'(flush_count), 32'd1);
    idle();

    // three frozen cycles on a slow data access
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle("dmem_wait");
      chk("dmem_frozen", 32'(ex_mem_en), 32'd0);
    end
    dmem_ready = 1;
    cycle("dmem_done");
    chk("dmem_stall_cnt", 32'(stall_cycles), 32'd4);
    dmem_req = 0; dmem_ready = 0;
    cycle("after_dmem");

    // fetch not ready alone
    imem_ready = 0;
    cycle("imem_wait");
    imem_ready = 1;

    // x0 destination never stalls
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1;
    cycle("rd_zero");
    idle();

    // reset in the middle of a data-memory wait
    dmem_req = 1;
    cycle("pre_rst_wait");
    do_reset("rst_in_wait");
    dmem_req = 0;
    cycle("post_rst_run");

    // halt then held, then reset out
    halt_req = 1;
    cycle("halt_req");
    chk("halted_flag", 32'(halted), 32'd1);
    for (int i = 0; i < 4; i++) begin
      randin();
      cycle("halt_hold");
    end
    do_reset("rst_in_halt");
    idle();
    cycle("post_halt");

    // random traffic with occasional asynchronous resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset("rnd_rst");
      randin();
      cycle("rnd");
    end

    // stall counter saturation
    do_reset("pre_sat");
    idle();
    imem_ready = 0;
    for (int i = 0; i < MAXC; i++) cycle("sat_fill");
    chk("sat_max", 32'(stall_cycles), 32'(MAXC));
    cycle("sat_hold");
    chk("sat_hold_max", 32'(stall_cycles), 32'(MAXC));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: REG_ADDR_W, default 5, register-index width.
REQ-002 Parameter: CNT_W, default 16, width of the performance counters.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Ports: id_rs1, id_rs2  input  REG_ADDR_W each  ID-stage source indices; id_rs1_used, id_rs2_used  input  1 each  source actually read.
REQ-006 Ports: ex_rd  input  REG_ADDR_W  EX-stage destination; ex_mem_read  input  1  EX instruction is a load.
REQ-007 Port: ex_branch_taken  input  1  redirect resolved in EX this cycle.
REQ-008 Ports: imem_ready  input  1  fetch data valid; dmem_req  input  1  MEM-stage access; dmem_ready  input  1  data access completes.
REQ-009 Port: halt_req  input  1  request permanent stop.
REQ-010 Ports: pc_en, if_id_en, if_id_stall, if_id_flush, id_ex_flush, ex_mem_en  output  1 each  pipeline control.
REQ-011 Ports: halted  output  1; stall_cycles, flush_count  output  CNT_W each  performance counters.

Function
REQ-012 State machine SHALL have states RUN, DMEM_WAIT, HALT; outputs are combinational from state and inputs; counters registered.
REQ-013 Load-use hazard SHALL be: ex_mem_read && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
REQ-014 In RUN, actions SHALL follow strict priority, first match wins: (1) dmem_req && !dmem_ready; (2) ex_branch_taken; (3) load-use hazard; (4) !imem_ready; (5) normal.
REQ-015 Rule 1 (freeze): pc_en=0, if_id_stall=1, ex_mem_en=0, both flushes 0; next state DMEM_WAIT.
REQ-016 Rule 2 (redirect): pc_en=1, if_id_flush=1, id_ex_flush=1, if_id_stall=0, ex_mem_en=1.
REQ-017 Rule 3 (bubble): pc_en=0, if_id_stall=1, id_ex_flush=1, if_id_flush=0, ex_mem_en=1.
REQ-018 Rule 4 (fetch wait): pc_en=0, if_id_flush=1 (NOP into ID), if_id_stall=0, id_ex_flush=0, ex_mem_en=1.
REQ-019 Rule 5 (normal): pc_en=1, ex_mem_en=1, stall and flushes 0.
REQ-020 if_id_en SHALL be 1 in RUN and DMEM_WAIT, 0 in HALT.
REQ-021 DMEM_WAIT SHALL ignore dmem_req, apply rule-1 outputs while dmem_ready=0; on dmem_ready=1 apply rules 2-5 that cycle and return to RUN.
REQ-022 halt_req SHALL be sampled only in RUN when rule 1 does not apply; that cycle's action completes, next state HALT.
REQ-023 HALT SHALL drive pc_en=0, if_id_en=0, ex_mem_en=0, flushes 0, if_id_stall=0, halted=1; exit only via rst.
REQ-024 if_id_stall and if_id_flush SHALL never be 1 in the same cycle.
REQ-025 stall_cycles SHALL increment by 1 on each clock edge in RUN or DMEM_WAIT where pc_en=0, saturating at 2^CNT_W-1.
REQ-026 flush_count SHALL increment by 1 on each clock edge where rule 2 was applied, saturating at 2^CNT_W-1.
REQ-027 ex_rd==0 SHALL never cause a load-use stall.

Reset
REQ-028 While rst=1: state RUN, counters 0, halted=0, all control outputs 0, regardless of clk.
REQ-029 rst asserted mid-DMEM_WAIT or in HALT SHALL return to RUN immediately; first cycle after release applies RUN rules.

Verification
REQ-030 Load x5 in EX (ex_mem_read=1, ex_rd=5), ID id_rs2=5 used -> one cycle pc_en=0, if_id_stall=1, id_ex_flush=1; stall_cycles 0->1.
REQ-031 ex_branch_taken=1 coincident with load-use hazard -> if_id_flush=1, id_ex_flush=1, pc_en=1, if_id_stall=0; flush_count 0->1.
REQ-032 dmem_req=1, dmem_ready=0 for 3 cycles then 1 -> 3 frozen cycles (ex_mem_en=0), DMEM_WAIT entered, RUN on 4th; stall_cycles=3.
REQ-033 imem_ready=0 with no other event -> pc_en=0, if_id_flush=1, id_ex_flush=0.
REQ-034 halt_req=1 in RUN -> halted=1 next cycle, all enables 0 held; rst pulse -> halted=0, counters 0.
REQ-035 Load ex_rd=0 matching id_rs1=0 used -> no stall; 2^CNT_W-1 stalls then another -> stall_cycles holds at max.
